fifo_frame_arbiter: RTL and testbench

- Write-side scheduler for the shared audio async FIFO, running in the clk_write domain.
- Arbitrates two sample sources (e.g. left/right audio channels) into one FIFO write port using round-robin.
- A grant covers a whole frame of FRAME_LEN samples and is issued only when the FIFO has room for that frame, so FFT frames are never interleaved or split.
- Each FIFO word carries a channel tag in its MSB.

---
 rtl/fifo_frame_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_frame_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_arbiter.sv
// Write-side frame scheduler for the shared audio async FIFO.
// Two sample sources are round-robin arbitrated onto one FIFO write port.
// A grant covers a whole frame, so frames never interleave or split. A grant
// is only issued once the FIFO is known to have room for the entire frame.
module fifo_frame_arbiter #(
    parameter int DATA_WIDTH       = 16,
    parameter int FIFO_DEPTH_WIDTH = 11,
    parameter int FRAME_LEN        = 256,
    parameter int CNT_W            = 16
) (
    input  logic                        clk_write,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [1:0]                  src_valid,
    input  logic [DATA_WIDTH-1:0]       src_data0,
    input  logic [DATA_WIDTH-1:0]       src_data1,
    output logic [1:0]                  src_ready,
    input  logic                        fifo_full,
    input  logic [FIFO_DEPTH_WIDTH-1:0] fifo_count_w,
    output logic                        fifo_write,
    output logic [DATA_WIDTH:0]         fifo_data,
    output logic                        busy,
    output logic                        grant_ch,
    output logic                        frame_done,
    output logic [CNT_W-1:0]            frames_ch0,
    output logic [CNT_W-1:0]            frames_ch1
);
    localparam int FW = FIFO_DEPTH_WIDTH;

    typedef enum logic [1:0] {IDLE, XFER, SETTLE} state_t;

    state_t        state;
    logic          rr_ptr;
    logic [FW-1:0] beat_cnt;   // FRAME_LEN <= 2**FW-1, so FW bits always suffice
    logic          settle_cnt;
    logic [FW:0]   free;
    logic          space_ok;
    logic          next_g;
    logic          beat;
    logic          last_beat;

    // The count wraps to 0 at full, so full forces free space to zero.
    assign free     = fifo_full ? '0 : (((FW+1)'(1)) << FW) - {1'b0, fifo_count_w};
    assign space_ok = !fifo_full && (free >= (FW+1)'(FRAME_LEN));

    // Both pending: round-robin pointer decides; otherwise the lone requester.
    assign next_g = (&src_valid) ? rr_ptr : src_valid[1];

    assign busy = (state != IDLE);

    assign beat      = (state == XFER) && !fifo_full &&
                       (grant_ch ? src_valid[1] : src_valid[0]);
    assign last_beat = beat && (beat_cnt == FW'(FRAME_LEN - 1));

    assign fifo_write = beat;
    assign fifo_data  = beat ? {grant_ch, (grant_ch ? src_data1 : src_data0)} : '0;

    // Ready only toward the granted source, and only while the FIFO accepts.
    always_comb begin
        src_ready = 2'b00;
        if (state == XFER && !fifo_full)
            src_ready[grant_ch] = 1'b1;
    end

    // Frame FSM: grant, count beats, then settle while fifo_count_w catches up.
    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            beat_cnt   <= '0;
            settle_cnt <= 1'b0;
            grant_ch   <= 1'b0;
            frame_done <= 1'b0;
            frames_ch0 <= '0;
            frames_ch1 <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && space_ok && (|src_valid)) begin
                        grant_ch <= next_g;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (last_beat) begin
                        frame_done <= 1'b1;
                        rr_ptr     <= ~grant_ch;
                        settle_cnt <= 1'b0;
                        state      <= SETTLE;
                        if (grant_ch) frames_ch1 <= frames_ch1 + 1'b1;
                        else          frames_ch0 <= frames_ch0 + 1'b1;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    settle_cnt <= 1'b1;
                    if (settle_cnt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_frame_arbiter.sv
// Directed bench for fifo_frame_arbiter: grants, frame length, round-robin,
// space gating, full stalls, valid gaps, en drop and mid-frame reset.
module tb_fifo_frame_arbiter;
    localparam int DW = 16;
    localparam int FW = 11;
    localparam int FL = 256;
    localparam int CW = 16;
    localparam logic [DW-1:0] D0 = 16'h1234;
    localparam logic [DW-1:0] D1 = 16'hBEEF;

    logic          clk_write = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    src_valid;
    logic [DW-1:0] src_data0;
    logic [DW-1:0] src_data1;
    logic [1:0]    src_ready;
    logic          fifo_full;
    logic [FW-1:0] fifo_count_w;
    logic          fifo_write;
    logic [DW:0]   fifo_data;
    logic          busy;
    logic          grant_ch;
    logic          frame_done;
    logic [CW-1:0] frames_ch0;
    logic [CW-1:0] frames_ch1;

    int checks = 0;
    int errors = 0;
    int nwr;
    int cyc;

    fifo_frame_arbiter #(
        .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(FW), .FRAME_LEN(FL), .CNT_W(CW)
    ) dut (
        .clk_write(clk_write), .rst_n(rst_n), .en(en), .src_valid(src_valid),
        .src_data0(src_data0), .src_data1(src_data1), .src_ready(src_ready),
        .fifo_full(fifo_full), .fifo_count_w(fifo_count_w),
        .fifo_write(fifo_write), .fifo_data(fifo_data), .busy(busy),
        .grant_ch(grant_ch), .frame_done(frame_done),
        .frames_ch0(frames_ch0), .frames_ch1(frames_ch1)
    );

    always #5 clk_write = ~clk_write;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; registered outputs are settled on return.
    task automatic clk1();
        @(posedge clk_write);
        #1;
    endtask

    // Run the granted frame until frame_done. mode 0 plain, 1 toggle
    // src_valid[0], 2 fifo_full for 5 cycles at beat 100, 3 drop en at beat 50.
    task automatic run_frame(input logic tag, input int mode, output int n, output int c);
        int stall;
        logic [DW:0] exp_word;
        n = 0; c = 0; stall = 0;
        exp_word = {tag, (tag ? D1 : D0)};
        while (c < 2000) begin
            if (mode == 1) src_valid[0] = ~c[0];
            if (mode == 2) fifo_full = (n == 100 && stall < 5);
            if (mode == 3 && n == 50) en = 1'b0;
            #1;
            if (fifo_full) begin
                chk("stall_ready", {30'd0, src_ready}, 32'd0);
                chk("stall_write", {31'd0, fifo_write}, 32'd0);
                stall++;
            end
            if (fifo_write) begin
                n++;
                chk("word", {15'd0, fifo_data}, {15'd0, exp_word});
            end
            clk1();
            c++;
            if (frame_done) break;
        end
        chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
        if (mode == 1) src_valid[0] = 1'b1;
        fifo_full = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; src_valid = 2'b00; fifo_full = 1'b0;
        fifo_count_w = '0; src_data0 = D0; src_data1 = D1;
        #12;
        // Reset state, with requests already asserted
        en = 1'b1; src_valid = 2'b11;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {30'd0, src_ready}, 32'd0);
        chk("rst_write", {31'd0, fifo_write}, 32'd0);
        chk("rst_data", {15'd0, fifo_data}, 32'd0);
        chk("rst_grant", {31'd0, grant_ch}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_f0", {16'd0, frames_ch0}, 32'd0);
        chk("rst_f1", {16'd0, frames_ch1}, 32'd0);
        rst_n = 1'b1;

        // Both pending: ch0 first, then ch1 after 3-cycle gap
        clk1();
        chk("g0_busy", {31'd0, busy}, 32'd1);
        chk("g0_grant", {31'd0, grant_ch}, 32'd0);
        #1;
        chk("g0_ready", {30'd0, src_ready}, 32'd1);
        run_frame(1'b0, 0, nwr, cyc);
        chk("f0_words", nwr, FL);
        chk("f0_cycles", cyc, FL);
        chk("f0_count", {16'd0, frames_ch0}, 32'd1);
        chk("settle1_busy", {31'd0, busy}, 32'd1);
        chk("settle1_ready", {30'd0, src_ready}, 32'd0);
        clk1();
        chk("settle2_done", {31'd0, frame_done}, 32'd0);
        chk("settle2_busy", {31'd0, busy}, 32'd1);
        clk1();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_grant_hold", {31'd0, grant_ch}, 32'd0);
        clk1();
        chk("g1_grant", {31'd0, grant_ch}, 32'd1);
        run_frame(1'b1, 0, nwr, cyc);
        chk("f1_words", nwr, FL);
        chk("f1_c0", {16'd0, frames_ch0}, 32'd1);
        chk("f1_c1", {16'd0, frames_ch1}, 32'd1);

        // Fresh start, only ch1 requesting: three back-to-back ch1 frames
        rst_n = 1'b0; src_valid = 2'b10;
        #1;
        rst_n = 1'b1;
        clk1();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin clk1(); clk1(); clk1(); end
            chk("solo_busy", {31'd0, busy}, 32'd1);
            chk("solo_grant", {31'd0, grant_ch}, 32'd1);
            run_frame(1'b1, 0, nwr, cyc);
            chk("solo_words", nwr, FL);
        end
        chk("solo_c1", {16'd0, frames_ch1}, 32'd3);
        chk("solo_c0", {16'd0, frames_ch0}, 32'd0);

        // Space gating: free 248 and 255 block, 256 grants
        src_valid = 2'b01; fifo_count_w = 11'd1800;
        clk1(); clk1(); clk1(); clk1();
        chk("nospace_busy", {31'd0, busy}, 32'd0);
        fifo_count_w = 11'd1793;
        clk1();
        chk("free255_busy", {31'd0, busy}, 32'd0);
        fifo_count_w = 11'd1792;
        clk1();
        chk("free256_busy", {31'd0, busy}, 32'd1);
        chk("free256_grant", {31'd0, grant_ch}, 32'd0);

        // fifo_full stall at beat 100 for 5 cycles
        run_frame(1'b0, 2, nwr, cyc);
        chk("full_words", nwr, FL);
        chk("full_cycles", cyc, FL + 5);
        fifo_count_w = '0;

        // Both requesting: rr gives ch1, then ch0 with gappy valid
        src_valid = 2'b11;
        clk1(); clk1(); clk1();
        chk("rr_grant1", {31'd0, grant_ch}, 32'd1);
        run_frame(1'b1, 0, nwr, cyc);
        clk1(); clk1(); clk1();
        chk("rr_grant0", {31'd0, grant_ch}, 32'd0);
        run_frame(1'b0, 1, nwr, cyc);
        chk("gap_words", nwr, FL);
        chk("gap_cycles", cyc, 2 * FL - 1);

        // en dropped at beat 50 (ch1 granted): frame completes, then IDLE holds
        clk1(); clk1(); clk1();
        chk("en_grant", {31'd0, grant_ch}, 32'd1);
        run_frame(1'b1, 3, nwr, cyc);
        chk("en_words", nwr, FL);
        clk1(); clk1(); clk1(); clk1(); clk1();
        chk("en_hold_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        clk1();
        chk("en_regrant", {31'd0, grant_ch}, 32'd0);
        chk("en_regrant_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 10; k++) clk1();
        #1;
        chk("pre_rst_write", {31'd0, fifo_write}, 32'd1);

        // Reset mid-frame: everything clears immediately
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_write", {31'd0, fifo_write}, 32'd0);
        chk("mrst_ready", {30'd0, src_ready}, 32'd0);
        chk("mrst_data", {15'd0, fifo_data}, 32'd0);
        chk("mrst_f0", {16'd0, frames_ch0}, 32'd0);
        chk("mrst_f1", {16'd0, frames_ch1}, 32'd0);
        chk("mrst_grant", {31'd0, grant_ch}, 32'd0);
        rst_n = 1'b1;
        clk1();
        chk("post_rst_grant", {31'd0, grant_ch}, 32'd0);
        run_frame(1'b0, 0, nwr, cyc);
        chk("post_rst_words", nwr, FL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
